// File: rtl/alu_muldiv_seq_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer: control bundle, ALU
// function codes with their HI/LO predicates, and the sequencer state encoding.
package alu_muldiv_seq_pkg;

    typedef struct packed {
        logic clk;
        logic rst;
    } Util_Control_T;

    localparam int Alu_Func_L = 6;
    typedef logic [Alu_Func_L-1:0] alu_func_t;

    localparam alu_func_t Alu_Func_Mfhi = 6'h10;
    localparam alu_func_t Alu_Func_Mthi = 6'h11;
    localparam alu_func_t Alu_Func_Mflo = 6'h12;
    localparam alu_func_t Alu_Func_Mtlo = 6'h13;
    localparam alu_func_t Alu_Func_Muls = 6'h18;
    localparam alu_func_t Alu_Func_Mulu = 6'h19;
    localparam alu_func_t Alu_Func_Divs = 6'h1A;
    localparam alu_func_t Alu_Func_Divu = 6'h1B;

    localparam int Alu_Seq_State_L = 2;
    typedef enum logic [Alu_Seq_State_L-1:0] {
        Alu_Seq_State_Idle  = 2'd0,
        Alu_Seq_State_Run   = 2'd1,
        Alu_Seq_State_Write = 2'd2
    } alu_seq_state_e;

    // Ceiling log2; callers pass (largest value + 1) to get a counter width.
    function automatic int Util_Math_log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic logic Alu_Func_isMul(input alu_func_t f);
        return (f == Alu_Func_Muls) || (f == Alu_Func_Mulu);
    endfunction

    function automatic logic Alu_Func_isMulDiv(input alu_func_t f);
        return (f == Alu_Func_Muls) || (f == Alu_Func_Mulu) ||
               (f == Alu_Func_Divs) || (f == Alu_Func_Divu);
    endfunction

    function automatic logic Alu_Func_isHiLo(input alu_func_t f);
        return Alu_Func_isMulDiv(f) || (f == Alu_Func_Mthi) || (f == Alu_Func_Mtlo);
    endfunction

endpackage

// File: rtl/alu_muldiv_seq_lat_counter.sv
// Loadable latency down-counter; saturates at zero and flags the final cycle.
module alu_lat_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] val_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/alu_muldiv_seq.sv
// HI/LO multiply/divide sequencer: accepts HI/LO ops from EX, times the
// datapath latency, pulses start, issues HI/LO writes and stalls the front end.
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = Util_Math_log2(((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT) + 1)
) (
    input  Util_Control_T ctrl_i,
    input  logic          op_valid_i,
    input  alu_func_t     op_func_i,
    output logic          op_ready_o,
    input  logic          flush_i,
    input  logic          rd_req_i,
    output logic          stall_o,
    output logic          unit_start_o,
    output alu_func_t     unit_func_o,
    output logic          store_hi_o,
    output logic          store_lo_o,
    output logic          busy_o
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;

    if (DATA_W < 1) begin : g_chk_data_w
        $error("alu_muldiv_seq: DATA_W must be at least 1");
    end
    if ((MUL_LAT < 1) || (DIV_LAT < 1)) begin : g_chk_lat
        $error("alu_muldiv_seq: MUL_LAT and DIV_LAT must be at least 1");
    end
    if ((1 << CNT_W) <= MAX_LAT) begin : g_chk_cnt_w
        $error("alu_muldiv_seq: CNT_W too narrow for the largest latency");
    end

    localparam logic [CNT_W-1:0] MUL_LAT_C = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_LAT_C = CNT_W'(DIV_LAT);

    logic clk;
    logic rst;
    assign clk = ctrl_i.clk;
    assign rst = ctrl_i.rst;

    alu_seq_state_e   state_q;
    alu_seq_state_e   state_d;
    alu_func_t        unit_func_q;
    alu_func_t        unit_func_d;

    logic             hl_op;
    logic             md_op;
    logic             ready;
    logic             accept;
    logic             cnt_load;
    logic             cnt_en;
    logic             cnt_last;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_val;
    logic [CNT_W-1:0] run_lat;

    assign hl_op   = Alu_Func_isHiLo(op_func_i);
    assign md_op   = Alu_Func_isMulDiv(op_func_i);
    assign ready   = (state_q == Alu_Seq_State_Idle) && !flush_i;
    assign accept  = op_valid_i && ready && hl_op;
    assign cnt_val = Alu_Func_isMul(op_func_i) ? MUL_LAT_C : DIV_LAT_C;
    // The counter sits at its loaded value only in the first RUN cycle.
    assign run_lat = Alu_Func_isMul(unit_func_q) ? MUL_LAT_C : DIV_LAT_C;

    alu_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_counter (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (cnt_load),
        .val_i  (cnt_val),
        .en_i   (cnt_en),
        .cnt_o  (cnt),
        .last_o (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= Alu_Seq_State_Idle;
            unit_func_q <= '0;
        end else begin
            state_q     <= state_d;
            unit_func_q <= unit_func_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        unit_func_d = unit_func_q;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        case (state_q)
            Alu_Seq_State_Idle: begin
                if (accept && md_op) begin
                    state_d     = Alu_Seq_State_Run;
                    unit_func_d = op_func_i;
                    cnt_load    = 1'b1;
                end
            end
            Alu_Seq_State_Run: begin
                if (flush_i) begin
                    state_d = Alu_Seq_State_Idle;
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_last) begin
                        state_d = Alu_Seq_State_Write;
                    end
                end
            end
            Alu_Seq_State_Write: begin
                state_d = Alu_Seq_State_Idle;
            end
            default: begin
                state_d = Alu_Seq_State_Idle;
            end
        endcase
    end

    // Everything is held at zero while reset is asserted, op_ready included.
    always_comb begin
        op_ready_o   = 1'b0;
        busy_o       = 1'b0;
        stall_o      = 1'b0;
        unit_start_o = 1'b0;
        unit_func_o  = '0;
        store_hi_o   = 1'b0;
        store_lo_o   = 1'b0;
        if (!rst) begin
            op_ready_o  = ready;
            busy_o      = (state_q != Alu_Seq_State_Idle);
            stall_o     = (rd_req_i || (op_valid_i && hl_op)) &&
                          (state_q != Alu_Seq_State_Idle);
            unit_func_o = unit_func_q;
            case (state_q)
                Alu_Seq_State_Idle: begin
                    if (accept && !md_op) begin
                        unit_func_o = op_func_i;
                        store_hi_o  = (op_func_i == Alu_Func_Mthi);
                        store_lo_o  = (op_func_i == Alu_Func_Mtlo);
                    end
                end
                Alu_Seq_State_Run: begin
                    unit_start_o = !flush_i && (cnt == run_lat);
                end
                Alu_Seq_State_Write: begin
                    store_hi_o = !flush_i;
                    store_lo_o = !flush_i;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
